// File: rtl/clk_250ms_500ms.sv
// ---------------------------------------------------------------------------
// clk_250ms_500ms
//   Divides the system clock down to two phase-locked square waves
//   (250 ms and 500 ms period, 50% duty) and emits a one-cycle strobe
//   that coincides with each rising edge of either wave.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz (multiple of 8, >= 16)
//
// Ports
//   clk_100mhz  in   system clock, rising edge active
//   rst         in   synchronous active-high reset
//   clk_250ms   out  250 ms square wave (registered)
//   clk_500ms   out  500 ms square wave (registered)
//   tick_250ms  out  one-cycle strobe with each clk_250ms rise (registered)
//   tick_500ms  out  one-cycle strobe with each clk_500ms rise (registered)
// ---------------------------------------------------------------------------
module clk_250ms_500ms #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk_100mhz,
    input  logic rst,
    output logic clk_250ms,
    output logic clk_500ms,
    output logic tick_250ms,
    output logic tick_500ms
);

    // Half-period lengths in cycles. CLK_HZ is a multiple of 8, so the
    // halving below is exact and HALF_250 == CLK_HZ/8.
    localparam int unsigned HALF_500 = CLK_HZ / 4;
    localparam int unsigned HALF_250 = HALF_500 / 2;
    localparam int unsigned CNT_W    = $clog2(HALF_250);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_250 - 1);

    // Declaration initialisers give simulation the reset values before the
    // first reset edge.
    logic [CNT_W-1:0] r_cnt      = '0;
    logic             r_clk_250  = 1'b0;
    logic             r_clk_500  = 1'b0;
    logic             r_tick_250 = 1'b0;
    logic             r_tick_500 = 1'b0;

    logic w_wrap;
    logic w_rise_250;

    assign w_wrap     = (r_cnt == CNT_LAST);
    // clk_250ms is about to go 0->1 at this edge.
    assign w_rise_250 = w_wrap & ~r_clk_250;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_cnt      <= '0;
            r_clk_250  <= 1'b0;
            r_clk_500  <= 1'b0;
            r_tick_250 <= 1'b0;
            r_tick_500 <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_clk_250 <= ~r_clk_250;
            end
            // The 500 ms wave toggles only on 250 ms rising edges, which keeps
            // the two waves phase-locked without a second counter.
            if (w_rise_250) begin
                r_clk_500 <= ~r_clk_500;
            end
            // Strobes are computed from the pre-edge state so they land in the
            // same cycle the corresponding wave becomes 1.
            r_tick_250 <= w_rise_250;
            r_tick_500 <= w_rise_250 & ~r_clk_500;
        end
    end

    assign clk_250ms  = r_clk_250;
    assign clk_500ms  = r_clk_500;
    assign tick_250ms = r_tick_250;
    assign tick_500ms = r_tick_500;

endmodule

// File: tb/tb_clk_250ms_500ms.sv
// ---------------------------------------------------------------------------
// tb_clk_250ms_500ms
//   Directed bench for clk_250ms_500ms with CLK_HZ=80 (HALF_250=10,
//   HALF_500=20). After edge n following reset release the expected outputs
//   are:
//     clk_250ms  = (n/10) odd
//     clk_500ms  = ((n+10)/20) odd
//     tick_250ms = (n % 20 == 10)
//     tick_500ms = (n % 40 == 10)
// ---------------------------------------------------------------------------
module tb_clk_250ms_500ms;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_250ms;
    logic clk_500ms;
    logic tick_250ms;
    logic tick_500ms;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    clk_250ms_500ms #(.CLK_HZ(80)) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .clk_250ms  (clk_250ms),
        .clk_500ms  (clk_500ms),
        .tick_250ms (tick_250ms),
        .tick_500ms (tick_500ms)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc edges after a release, checking every cycle against the
    // closed-form expectation. Returns the number of observed rises.
    task automatic run_check(input int unsigned ncyc, output int unsigned rises250,
                             output int unsigned rises500);
        logic [3:0]  exp_v;
        logic [3:0]  obs_v;
        logic        prev_t250;
        logic        prev_t500;
        logic        prev_c250;
        logic        prev_c500;
        rises250  = 0;
        rises500  = 0;
        prev_t250 = tick_250ms;
        prev_t500 = tick_500ms;
        prev_c250 = clk_250ms;
        prev_c500 = clk_500ms;
        for (int unsigned n = 1; n <= ncyc; n++) begin
            edge_sample();
            exp_v[3] = ((n / 10) % 2) == 1;
            exp_v[2] = (((n + 10) / 20) % 2) == 1;
            exp_v[1] = (n % 20) == 10;
            exp_v[0] = (n % 40) == 10;
            obs_v    = {clk_250ms, clk_500ms, tick_250ms, tick_500ms};
            chk($sformatf("outputs@n%0d", n), 32'(obs_v), 32'(exp_v));
            chk($sformatf("cnt_le_9@n%0d", n), 32'(dut.r_cnt <= 4'd9), 32'd1);
            chk($sformatf("no_double_tick@n%0d", n),
                32'((prev_t250 & tick_250ms) | (prev_t500 & tick_500ms)), 32'd0);
            chk($sformatf("tick500_implies_tick250@n%0d", n),
                32'(tick_500ms & ~tick_250ms), 32'd0);
            if (clk_250ms && !prev_c250) rises250++;
            if (clk_500ms && !prev_c500) rises500++;
            prev_t250 = tick_250ms;
            prev_t500 = tick_500ms;
            prev_c250 = clk_250ms;
            prev_c500 = clk_500ms;
        end
    endtask

    initial begin
        int unsigned r250;
        int unsigned r500;

        // Power-up values before any reset.
        #1;
        chk("init_clk_250ms", 32'(clk_250ms), 32'd0);
        chk("init_clk_500ms", 32'(clk_500ms), 32'd0);
        chk("init_tick_250ms", 32'(tick_250ms), 32'd0);
        chk("init_tick_500ms", 32'(tick_500ms), 32'd0);

        // Let it free-run a while so reset has something to clear.
        repeat (13) edge_sample();

        // Hold reset for 3 edges; outputs must be 0 throughout.
        rst = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            edge_sample();
            chk($sformatf("rst_outputs_%0d", i),
                32'({clk_250ms, clk_500ms, tick_250ms, tick_500ms}), 32'd0);
            chk($sformatf("rst_cnt_%0d", i), 32'(dut.r_cnt), 32'd0);
        end
        rst = 1'b0;

        // 200 cycles of free running from release.
        run_check(200, r250, r500);
        chk("rises_250_in_200", r250, 32'd10);
        chk("rises_500_in_200", r500, 32'd5);

        // Fresh start, then a 1-cycle reset at cycle 15 (clk_250ms high).
        rst = 1'b1;
        edge_sample();
        rst = 1'b0;
        run_check(15, r250, r500);
        chk("pre_midrst_clk_250ms", 32'(clk_250ms), 32'd1);
        chk("pre_midrst_clk_500ms", 32'(clk_500ms), 32'd1);
        rst = 1'b1;
        edge_sample();
        rst = 1'b0;
        chk("midrst_outputs",
            32'({clk_250ms, clk_500ms, tick_250ms, tick_500ms}), 32'd0);
        chk("midrst_cnt", 32'(dut.r_cnt), 32'd0);

        // Timing restarts: first rise exactly 10 edges after release.
        run_check(9, r250, r500);
        chk("post_midrst_no_rise_by_9", r250, 32'd0);
        edge_sample();
        chk("post_midrst_rise_at_10",
            32'({clk_250ms, clk_500ms, tick_250ms, tick_500ms}), 32'hF);
        edge_sample();
        chk("post_midrst_ticks_drop_at_11",
            32'({clk_250ms, clk_500ms, tick_250ms, tick_500ms}), 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_250ms_500ms.md
CLK_250MS_500MS -- requirements
Module: clk_250ms_500ms

Interface
REQ-001 Parameter CLK_HZ SHALL have default 100_000_000 and give the input clock frequency in Hz; it SHALL be a multiple of 8 and at least 16.
REQ-002 Derived constant HALF_250 SHALL equal CLK_HZ/8, the cycles per half-period of the 250 ms clock (12_500_000 at the default).
REQ-003 Derived constant HALF_500 SHALL equal CLK_HZ/4, the cycles per half-period of the 500 ms clock (25_000_000 at the default).
REQ-004 Port clk_100mhz SHALL be an input, 1 bit wide, and is the single system clock; all logic uses its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and is the reset: synchronous, active-high.
REQ-006 Port clk_250ms SHALL be an output, 1 bit wide, carrying a square wave with a 250 ms period and 50% duty.
REQ-007 Port clk_500ms SHALL be an output, 1 bit wide, carrying a square wave with a 500 ms period and 50% duty.
REQ-008 Port tick_250ms SHALL be an output, 1 bit wide, carrying a one-cycle strobe coincident with each rising edge of clk_250ms.
REQ-009 Port tick_500ms SHALL be an output, 1 bit wide, carrying a one-cycle strobe coincident with each rising edge of clk_500ms.
REQ-010 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-011 Counter cnt SHALL be ceil(log2(HALF_250)) bits wide, 24 bits at the default.
REQ-012 When cnt == HALF_250-1: cnt <= 0 and clk_250ms <= ~clk_250ms; otherwise cnt <= cnt+1.
REQ-013 clk_500ms SHALL toggle on exactly the cycles in which clk_250ms goes 0->1 (phase-locked; no separate counter is required).
REQ-014 Both output waveforms SHALL be exact: every high and low phase of clk_250ms is HALF_250 cycles, and every phase of clk_500ms is HALF_500 cycles, with no drift or jitter.
REQ-015 tick_250ms SHALL be 1 in exactly the cycles in which the registered clk_250ms is 1 and was 0 in the previous cycle.
REQ-016 tick_500ms SHALL be asserted likewise for clk_500ms, so it coincides with every second tick_250ms.
REQ-017 Timing: with edge 1 defined as the first rising edge with rst=0, clk_250ms and tick_250ms go high after edge HALF_250, and clk_500ms and tick_500ms go high after the same edge.
REQ-018 Counter wrap SHALL occur only at HALF_250-1; cnt SHALL never exceed HALF_250-1.
REQ-019 There SHALL be no other inputs; the block free-runs whenever rst=0.

Reset
REQ-020 While rst=1 at a clock edge: cnt<=0, clk_250ms<=0, clk_500ms<=0, tick_250ms<=0 and tick_500ms<=0.
REQ-021 Reset SHALL have priority over counting.
REQ-022 Assertion of rst mid-period SHALL abandon the current phase, and timing SHALL restart per REQ-017 after release.
REQ-023 Before the first reset, output values are unspecified; simulation SHALL use initial values equal to the reset values.

Verification (CLK_HZ=80, so HALF_250=10 and HALF_500=20)
REQ-024 Scenario: hold rst 3 cycles, then release -> all outputs 0 during reset; clk_250ms and clk_500ms rise after edge 10; tick_250ms and tick_500ms are 1 for exactly that one cycle.
REQ-025 Scenario: run 200 cycles -> clk_250ms has period 20 cycles with 10 cycles high, and clk_500ms has period 40 cycles with 20 cycles high.
REQ-026 Scenario: run 200 cycles -> tick_250ms pulses every 20 cycles, tick_500ms pulses every 40 cycles, and every tick_500ms coincides with a tick_250ms.
REQ-027 Scenario: assert rst for 1 cycle at cycle 15, then release -> outputs are 0 in the next cycle, and the next rise occurs 10 edges after release.
REQ-028 Scenario: check at every cycle -> cnt <= 9, and no tick is asserted for 2 consecutive cycles.
REQ-029 Scenario: default parameters with a short run of 25_000_001 cycles -> exactly one clk_250ms rise, at cycle 12_500_000.
